// File: rtl/nf_axis_be_le_skid_bridge.sv
// -----------------------------------------------------------------------------
// nf_axis_be_le_skid_bridge
//
// Purpose:
//   Registered AXI4-Stream stage that converts the big-endian internal
//   datapath byte order to the little-endian order expected by the MAC/DMA
//   side. tdata byte lanes and tkeep bits are mirrored; tuser and tlast pass
//   through unchanged. A main register plus a skid register sustain one beat
//   per cycle while keeping s_axis_tready fully registered.
//
// Parameters:
//   C_AXIS_DATA_WIDTH  - tdata width in bits (multiple of 8, 16..512)
//   C_AXIS_TUSER_WIDTH - tuser width in bits (passed through)
//
// Ports:
//   clk, reset            - single clock, asynchronous active-high reset
//   s_axis_*              - big-endian ingress stream (tready is registered)
//   m_axis_*              - little-endian egress stream (driven from main reg)
//   stat_pkt_count        - packets emitted         (NF_ENDIAN_BRIDGE_STATS_EN)
//   stat_beat_count       - beats emitted           (NF_ENDIAN_BRIDGE_STATS_EN)
//   stat_keep_err_count   - non-last partial beats  (NF_ENDIAN_BRIDGE_STATS_EN)
//
// Build option:
//   Define NF_ENDIAN_BRIDGE_STATS_EN to add the statistics ports/counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module nf_axis_be_le_skid_bridge #(
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready
`ifdef NF_ENDIAN_BRIDGE_STATS_EN
  ,
  output logic [31:0]                     stat_pkt_count,
  output logic [31:0]                     stat_beat_count,
  output logic [31:0]                     stat_keep_err_count
`endif
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t  state_q, state_d;
  logic    m_tvalid_q, m_tvalid_d;
  logic    s_tready_q, s_tready_d;
  logic    in_hs, out_hs;
  logic    load_main_in, load_main_skid, load_skid;

  // Byte-lane / keep-bit mirror of the incoming beat.
  logic [DW-1:0] swap_data;
  logic [KW-1:0] swap_keep;

  for (genvar gi = 0; gi < KW; gi++) begin : g_lane
    assign swap_data[8*gi +: 8] = s_axis_tdata[8*(KW-1-gi) +: 8];
    assign swap_keep[gi]        = s_axis_tkeep[KW-1-gi];
  end

  // Payload storage (already in little-endian order).
  logic [DW-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [KW-1:0] main_keep_q, main_keep_d, skid_keep_q, skid_keep_d;
  logic [UW-1:0] main_user_q, main_user_d, skid_user_q, skid_user_d;
  logic          main_last_q, main_last_d, skid_last_q, skid_last_d;

  assign in_hs  = s_axis_tvalid & s_tready_q;
  assign out_hs = m_tvalid_q & m_axis_tready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_hs) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_hs && out_hs) begin
          load_main_in = 1'b1;
        end else if (in_hs) begin
          // Downstream stalled: park the new beat, main keeps its beat.
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_hs) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // s_tready is low here, so only a drain can happen.
        if (out_hs) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Handshake outputs are registered from the next state, so ready never
    // depends combinationally on m_axis_tready.
    m_tvalid_d = (state_d != ST_EMPTY);
    s_tready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      m_tvalid_q <= 1'b0;
      s_tready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_tvalid_q <= m_tvalid_d;
      s_tready_q <= s_tready_d;
    end
  end

  always_comb begin
    main_data_d = main_data_q;
    main_keep_d = main_keep_q;
    main_user_d = main_user_q;
    main_last_d = main_last_q;
    skid_data_d = skid_data_q;
    skid_keep_d = skid_keep_q;
    skid_user_d = skid_user_q;
    skid_last_d = skid_last_q;
    if (load_main_in) begin
      main_data_d = swap_data;
      main_keep_d = swap_keep;
      main_user_d = s_axis_tuser;
      main_last_d = s_axis_tlast;
    end else if (load_main_skid) begin
      main_data_d = skid_data_q;
      main_keep_d = skid_keep_q;
      main_user_d = skid_user_q;
      main_last_d = skid_last_q;
    end
    if (load_skid) begin
      skid_data_d = swap_data;
      skid_keep_d = swap_keep;
      skid_user_d = s_axis_tuser;
      skid_last_d = s_axis_tlast;
    end
  end

  // Payload flops carry no reset; validity is tracked by the state flops.
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    main_keep_q <= main_keep_d;
    main_user_q <= main_user_d;
    main_last_q <= main_last_d;
    skid_data_q <= skid_data_d;
    skid_keep_q <= skid_keep_d;
    skid_user_q <= skid_user_d;
    skid_last_q <= skid_last_d;
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = main_data_q;
  assign m_axis_tkeep  = main_keep_q;
  assign m_axis_tuser  = main_user_q;
  assign m_axis_tlast  = main_last_q;

`ifdef NF_ENDIAN_BRIDGE_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] keep_err_cnt_q, keep_err_cnt_d;

  always_comb begin
    pkt_cnt_d      = pkt_cnt_q;
    beat_cnt_d     = beat_cnt_q;
    keep_err_cnt_d = keep_err_cnt_q;
    if (out_hs) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (main_last_q) begin
        pkt_cnt_d = pkt_cnt_q + 32'd1;
      end else if (main_keep_q != {KW{1'b1}}) begin
        keep_err_cnt_d = keep_err_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt_q      <= 32'd0;
      beat_cnt_q     <= 32'd0;
      keep_err_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q      <= pkt_cnt_d;
      beat_cnt_q     <= beat_cnt_d;
      keep_err_cnt_q <= keep_err_cnt_d;
    end
  end

  assign stat_pkt_count      = pkt_cnt_q;
  assign stat_beat_count     = beat_cnt_q;
  assign stat_keep_err_count = keep_err_cnt_q;
`endif

endmodule

// File: tb/tb_nf_axis_be_le_skid_bridge.sv
// -----------------------------------------------------------------------------
// tb_nf_axis_be_le_skid_bridge
//
// Scoreboard bench for the big-endian to little-endian skid bridge. Accepted
// input beats are converted by a reference model and queued; output beats are
// popped and compared in order. Scenario tasks run in sequence from one
// initial block. Statistics checks are compiled in with
// NF_ENDIAN_BRIDGE_STATS_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nf_axis_be_le_skid_bridge;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int UW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
`ifdef NF_ENDIAN_BRIDGE_STATS_EN
  logic [31:0]   stat_pkt_count;
  logic [31:0]   stat_beat_count;
  logic [31:0]   stat_keep_err_count;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    beats_seen   = 0;

  always #5 clk = ~clk;

  nf_axis_be_le_skid_bridge #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
`ifdef NF_ENDIAN_BRIDGE_STATS_EN
    ,
    .stat_pkt_count     (stat_pkt_count),
    .stat_beat_count    (stat_beat_count),
    .stat_keep_err_count(stat_keep_err_count)
`endif
  );

  // Reference conversion: output byte i comes from input byte N-1-i.
  function automatic beat_t model(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                  input logic [UW-1:0] u, input logic l);
    beat_t b;
    for (int i = 0; i < KW; i++) begin
      b.data[8*i +: 8] = d[8*(KW-1-i) +: 8];
      b.keep[i]        = k[KW-1-i];
    end
    b.user = u;
    b.last = l;
    return b;
  endfunction

  function automatic beat_t observed();
    return {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
  endfunction

  // Load a fresh random payload onto the slave inputs (does not touch tvalid).
  task automatic drive_random(input logic [KW-1:0] keep, input logic last);
    s_axis_tdata = {$urandom, $urandom};
    s_axis_tkeep = keep;
    s_axis_tuser = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tlast = last;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (m_axis_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_m_tvalid: got %b, required 0", m_axis_tvalid);
    end
    tests_run++;
    if (s_axis_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_s_tready: got %b, required 0", s_axis_tready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (s_axis_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_ready_early: got %b, required 0", s_axis_tready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_ready: got ready=%b valid=%b, required ready=1 valid=0",
               s_axis_tready, m_axis_tvalid);
    end
    $display("[TB] reset sequence done");
  endtask

  // One isolated beat with fixed expected values, checking one-cycle latency.
  task automatic test_single_beat(input string name, input logic [DW-1:0] d,
                                  input logic [KW-1:0] k, input logic [DW-1:0] exp_d,
                                  input logic [KW-1:0] exp_k);
    logic [UW-1:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_pre: got ready=%b valid=%b, required ready=1 valid=0",
               name, s_axis_tready, m_axis_tvalid);
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d || m_axis_tkeep !== exp_k ||
        m_axis_tlast !== 1'b1 || m_axis_tuser !== u) begin
      tests_failed++;
      $display("FAIL %s: got valid=%b data=%h keep=%h last=%b, required valid=1 data=%h keep=%h last=1",
               name, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, exp_d, exp_k);
    end
    $display("[TB] %s out data=%h keep=%h last=%b", name, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (m_axis_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_drain: got valid=%b, required 0", name, m_axis_tvalid);
    end
  endtask

  task automatic test_back_pressure();
    beat_t e, got, held;
    bit    in_hs = 0, out_hs = 0, pend = 0, stall_prev = 0;
    int    occ = 0, n_drv = 0, recv = 0, cyc = 0;
    bit    pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    held = '0;
    while (recv < 8 && cyc < 400) begin
      @(posedge clk); #1;
      occ = occ + int'(in_hs) - int'(out_hs);
      if (in_hs) pend = 0;
      if (!pend && n_drv < 8 && $urandom_range(0, 1) == 1) begin
        drive_random({KW{1'b1}}, (n_drv == 7));
        n_drv++;
        pend = 1;
      end
      s_axis_tvalid = pend;
      m_axis_tready = pattern[cyc % 4];
      @(negedge clk);
      tests_run++;
      if (s_axis_tready !== (occ != 2) || m_axis_tvalid !== (occ != 0)) begin
        tests_failed++;
        $display("FAIL bp_flags cyc %0d: got ready=%b valid=%b, required ready=%b valid=%b",
                 cyc, s_axis_tready, m_axis_tvalid, (occ != 2), (occ != 0));
      end
      if (stall_prev) begin
        tests_run++;
        if (m_axis_tvalid !== 1'b1 || observed() !== held) begin
          tests_failed++;
          $display("FAIL bp_stable cyc %0d: got valid=%b data=%h, required valid=1 data=%h",
                   cyc, m_axis_tvalid, m_axis_tdata, held.data);
        end
      end
      in_hs  = s_axis_tvalid && s_axis_tready;
      out_hs = m_axis_tvalid && m_axis_tready;
      if (in_hs) exp_q.push_back(model(s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast));
      if (out_hs) begin
        got = observed();
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL bp_extra_beat: got data=%h, required no beat", got.data);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            tests_failed++;
            $display("FAIL bp_beat %0d: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                     recv, got.data, got.keep, got.last, e.data, e.keep, e.last);
          end
        end
        $display("[TB] bp beat %0d data=%h last=%b", recv, got.data, got.last);
        recv++;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held = observed();
      cyc++;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    tests_run++;
    if (recv != 8 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d beats (%0d pending), required 8 (0 pending)", recv, exp_q.size());
    end
  endtask

  task automatic test_throughput();
    beat_t e, got;
    bit    in_hs = 0, out_hs = 0, pend = 0;
    int    n_drv = 0, recv = 0;
    int    first_acc = -1, last_acc = -1, first_out = -1, last_out = -1;
    m_axis_tready = 1'b1;
    for (int cyc = 0; cyc < 300 && recv < 64; cyc++) begin
      @(posedge clk); #1;
      if (in_hs) pend = 0;
      if (!pend && n_drv < 64) begin
        drive_random({KW{1'b1}}, (n_drv % 8) == 7);
        n_drv++;
        pend = 1;
      end
      s_axis_tvalid = pend;
      @(negedge clk);
      in_hs  = s_axis_tvalid && s_axis_tready;
      out_hs = m_axis_tvalid && m_axis_tready;
      if (in_hs) begin
        exp_q.push_back(model(s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast));
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (out_hs) begin
        got = observed();
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL tp_extra_beat: got data=%h, required no beat", got.data);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            tests_failed++;
            $display("FAIL tp_beat %0d: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                     recv, got.data, got.keep, got.last, e.data, e.keep, e.last);
          end
        end
        $display("[TB] tp beat %0d data=%h last=%b", recv, got.data, got.last);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        recv++;
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    tests_run++;
    if (recv != 64 || (last_out - first_out) != 63 || (last_acc - first_acc) != 63) begin
      tests_failed++;
      $display("FAIL tp_rate: got %0d beats over out span %0d, in span %0d, required 64 over 63/63",
               recv, last_out - first_out, last_acc - first_acc);
    end
    tests_run++;
    if (first_out != first_acc + 1) begin
      tests_failed++;
      $display("FAIL tp_latency: got first out cycle %0d, required %0d", first_out, first_acc + 1);
    end
  endtask

  task automatic test_reset_mid_packet();
    beat_t e, got;
    bit    in_hs = 0, out_hs = 0, pend = 0;
    int    n_drv = 0, recv = 0, n_acc = 0;
    m_axis_tready = 1'b0;
    // Fill main and skid while downstream is stalled.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive_random({KW{1'b1}}, 1'b0);
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      if (s_axis_tready) n_acc++;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (n_acc != 2 || s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_full: got accepted=%0d ready=%b valid=%b, required 2/0/1",
               n_acc, s_axis_tready, m_axis_tvalid);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: got valid=%b ready=%b, required 0/0", m_axis_tvalid, s_axis_tready);
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_release_early: got ready=%b valid=%b, required 0/0", s_axis_tready, m_axis_tvalid);
    end
    for (int cyc = 0; cyc < 50 && recv < 3; cyc++) begin
      @(posedge clk); #1;
      if (in_hs) pend = 0;
      if (!pend && n_drv < 3) begin
        drive_random({KW{1'b1}}, n_drv == 2);
        n_drv++;
        pend = 1;
      end
      s_axis_tvalid = pend;
      @(negedge clk);
      if (cyc == 0) begin
        tests_run++;
        if (s_axis_tready !== 1'b1) begin
          tests_failed++;
          $display("FAIL rst_release_ready: got %b, required 1", s_axis_tready);
        end
      end
      in_hs  = s_axis_tvalid && s_axis_tready;
      out_hs = m_axis_tvalid && m_axis_tready;
      if (in_hs) exp_q.push_back(model(s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast));
      if (out_hs) begin
        got = observed();
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rst_extra_beat: got data=%h, required no beat", got.data);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            tests_failed++;
            $display("FAIL rst_beat %0d: got data=%h last=%b, required data=%h last=%b",
                     recv, got.data, got.last, e.data, e.last);
          end
        end
        $display("[TB] post-reset beat %0d data=%h last=%b", recv, got.data, got.last);
        recv++;
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    tests_run++;
    if (recv != 3) begin
      tests_failed++;
      $display("FAIL rst_packet_count: got %0d beats, required 3", recv);
    end
  endtask

`ifdef NF_ENDIAN_BRIDGE_STATS_EN
  task automatic test_stats();
    beat_t e, got;
    bit    in_hs = 0, out_hs = 0, pend = 0;
    int    n_drv = 0, recv = 0;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++;
    if (stat_pkt_count !== 32'd0 || stat_beat_count !== 32'd0 || stat_keep_err_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL stats_reset: got pkt=%0d beat=%0d kerr=%0d, required 0/0/0",
               stat_pkt_count, stat_beat_count, stat_keep_err_count);
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 100 && recv < 12; cyc++) begin
      @(posedge clk); #1;
      if (in_hs) pend = 0;
      if (!pend && n_drv < 12) begin
        drive_random((n_drv == 1) ? 8'h0F : 8'hFF, (n_drv % 4) == 3);
        n_drv++;
        pend = 1;
      end
      s_axis_tvalid = pend;
      @(negedge clk);
      in_hs  = s_axis_tvalid && s_axis_tready;
      out_hs = m_axis_tvalid && m_axis_tready;
      if (in_hs) exp_q.push_back(model(s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast));
      if (out_hs) begin
        got = observed();
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL stats_extra_beat: got data=%h, required no beat", got.data);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            tests_failed++;
            $display("FAIL stats_beat %0d: got data=%h keep=%h, required data=%h keep=%h",
                     recv, got.data, got.keep, e.data, e.keep);
          end
        end
        $display("[TB] stats beat %0d keep=%h last=%b", recv, got.keep, got.last);
        recv++;
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    tests_run++;
    if (recv != 12 || stat_pkt_count !== 32'd3 || stat_beat_count !== 32'd12 ||
        stat_keep_err_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL stats_counts: got beats=%0d pkt=%0d beat=%0d kerr=%0d, required 12/3/12/1",
               recv, stat_pkt_count, stat_beat_count, stat_keep_err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_beat("byte_swap", 64'h0011223344556677, 8'hFF, 64'h7766554433221100, 8'hFF);
    test_single_beat("partial_last", 64'hAABBCC0000000000, 8'hE0, 64'h0000000000CCBBAA, 8'h07);
    test_back_pressure();
    test_throughput();
    test_reset_mid_packet();
`ifdef NF_ENDIAN_BRIDGE_STATS_EN
    test_stats();
`endif
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_queue: got %0d pending beats, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
